// File: rtl/rib_xbar_pkg.sv
// rib_xbar_pkg: shared state encodings, address field positions and transaction type for rib_xbar
// Contents: ST_* FSM encodings, REG_HI/REG_LO region nibble position, ERR_RDATA, txn_t latched request.
package rib_xbar_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RSP  = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;
   localparam int REG_HI = 31;
   localparam int REG_LO = 28;
   localparam logic [31:0] ERR_RDATA = 32'h0;
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;
endpackage

// File: rtl/rib_xbar_if.sv
// rib_xbar_if: bundle of master-side and slave-side bus signals around rib_xbar
// Master side: m_req/m_we/m_addr/m_wdata in, m_gnt/m_rvalid/m_rdata/m_err out.
// Slave side: s_req/s_we/s_addr/s_wdata out, s_gnt/s_rvalid/s_rdata in.
// Modport master is the crossbar's view, modport slave the surrounding system's view.
interface rib_xbar_if #(
   parameter int NM = 2,
   parameter int NS = 2
);
   logic [NM-1:0]       m_req;
   logic [NM-1:0]       m_we;
   logic [NM-1:0][31:0] m_addr;
   logic [NM-1:0][31:0] m_wdata;
   logic [NM-1:0]       m_gnt;
   logic [NM-1:0]       m_rvalid;
   logic [31:0]         m_rdata;
   logic                m_err;
   logic [NS-1:0]       s_req;
   logic                s_we;
   logic [31:0]         s_addr;
   logic [31:0]         s_wdata;
   logic [NS-1:0]       s_gnt;
   logic [NS-1:0]       s_rvalid;
   logic [NS-1:0][31:0] s_rdata;
   modport master (
      input  m_req, m_we, m_addr, m_wdata, s_gnt, s_rvalid, s_rdata,
      output m_gnt, m_rvalid, m_rdata, m_err, s_req, s_we, s_addr, s_wdata
   );
   modport slave (
      output m_req, m_we, m_addr, m_wdata, s_gnt, s_rvalid, s_rdata,
      input  m_gnt, m_rvalid, m_rdata, m_err, s_req, s_we, s_addr, s_wdata
   );
endinterface

// File: rtl/rib_xbar_rr_arb.sv
// rib_xbar_rr_arb: combinational round-robin arbiter, search starts at (last+1) mod NM
// Ports: req (NM request vector), last (previous winner index), gnt (one-hot winner), idx (winner index).
module rib_xbar_rr_arb #(
   parameter int NM = 2,
   parameter int IW = NM > 1 ? $clog2(NM) : 1
) (
   input  logic [NM-1:0] req,
   input  logic [IW-1:0] last,
   output logic [NM-1:0] gnt,
   output logic [IW-1:0] idx
);
   int c;
   // Walk the rotation backwards so the candidate closest after last overwrites the others.
   always_comb begin
      c = 0;
      idx = '0;
      for (int k = NM; k >= 1; k--) begin
         c = (int'(last) + k) % NM;
         if (req[c]) idx = IW'(c);
      end
      gnt = |req ? NM'(1) << idx : '0;
   end
endmodule

// File: rtl/rib_xbar.sv
// rib_xbar: round-robin NM-master / NS-slave bus interconnect with one transaction in flight
// Ports: clk, rst (synchronous, active-high); bus (rib_xbar_if.master) with m_* master-side
// request/response and s_* slave-side request/response signals.
// Unmapped addresses and slaves that overrun TIMEOUT cycles get an error response (m_err, m_rdata=0).
module rib_xbar
   import rib_xbar_pkg::*;
#(
   parameter int NM = 2,
   parameter int NS = 2,
   parameter logic [NS*4-1:0] SLV_REGION = {4'h1, 4'h0},
   parameter int TIMEOUT = 16
) (
   input logic clk,
   input logic rst,
   rib_xbar_if.master bus
);
   localparam int IW = NM > 1 ? $clog2(NM) : 1;
   localparam int SW = NS > 1 ? $clog2(NS) : 1;
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam bit TMO_EN = TIMEOUT > 0;
   localparam logic [CW-1:0] TMO_LAST = CW'(TMO_EN ? TIMEOUT - 1 : 0);

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] win_q, win_d, last_q, last_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   txn_t          txn_q, txn_d;
   logic [NM-1:0] rvalid_q, rvalid_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [NM-1:0] arb_gnt;
   logic [IW-1:0] arb_idx;
   logic          hit, start, tmo, gnt_now, rsp_ok, rsp_err, s_gnt_sel, s_rvalid_sel;
   logic [SW-1:0] dec_sel;

   rib_xbar_rr_arb #(.NM(NM), .IW(IW)) u_arb (
      .req  (bus.m_req),
      .last (last_q),
      .gnt  (arb_gnt),
      .idx  (arb_idx)
   );

   // Descending scan lets the lowest-numbered slave win on duplicate regions.
   always_comb begin
      hit = 1'b0;
      dec_sel = '0;
      for (int i = NS - 1; i >= 0; i--) begin
         if (bus.m_addr[arb_idx][REG_HI:REG_LO] == SLV_REGION[4*i +: 4]) begin
            hit = 1'b1;
            dec_sel = SW'(i);
         end
      end
   end

   // cnt_q keeps counting across REQ and RSP; >= catches a grant taken in the last REQ cycle.
   always_comb begin
      s_gnt_sel = bus.s_gnt[sel_q];
      s_rvalid_sel = bus.s_rvalid[sel_q];
      tmo = TMO_EN && cnt_q >= TMO_LAST;
      start = state_q == ST_IDLE && |arb_gnt;
      rsp_ok = state_q == ST_RSP && s_rvalid_sel;
      rsp_err = state_q == ST_ERR || (state_q == ST_REQ && !s_gnt_sel && tmo)
         || (state_q == ST_RSP && !s_rvalid_sel && tmo);
      gnt_now = state_q == ST_ERR || (state_q == ST_REQ && (s_gnt_sel || tmo));
      state_d = start ? (hit ? ST_REQ : ST_ERR)
         : (rsp_ok || rsp_err) ? ST_IDLE
         : (state_q == ST_REQ && s_gnt_sel) ? ST_RSP : state_q;
      win_d = start ? arb_idx : win_q;
      last_d = start ? arb_idx : last_q;
      sel_d = start ? dec_sel : sel_q;
      txn_d = start ? {bus.m_we[arb_idx], 4'h0, bus.m_addr[arb_idx][27:0], bus.m_wdata[arb_idx]} : txn_q;
      cnt_d = (state_q == ST_REQ || state_q == ST_RSP) ? cnt_q + 1'b1 : '0;
      rvalid_d = (rsp_ok || rsp_err) ? NM'(1) << win_q : '0;
      rdata_d = rsp_ok ? bus.s_rdata[sel_q] : ERR_RDATA;
      err_d = rsp_err;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         win_q <= '0;
         last_q <= IW'(NM - 1);
         sel_q <= '0;
         cnt_q <= '0;
         txn_q <= '0;
         rvalid_q <= '0;
         rdata_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q <= win_d;
         last_q <= last_d;
         sel_q <= sel_d;
         cnt_q <= cnt_d;
         txn_q <= txn_d;
         rvalid_q <= rvalid_d;
         rdata_q <= rdata_d;
         err_q <= err_d;
      end
   end

   assign bus.m_gnt = gnt_now ? NM'(1) << win_q : '0;
   assign bus.m_rvalid = rvalid_q;
   assign bus.m_rdata = rdata_q;
   assign bus.m_err = err_q;
   assign bus.s_req = state_q == ST_REQ ? NS'(1) << sel_q : '0;
   assign bus.s_we = txn_q.we;
   assign bus.s_addr = txn_q.addr;
   assign bus.s_wdata = txn_q.wdata;
endmodule

// File: tb/tb_rib_xbar.sv
// tb_rib_xbar: randomized self-checking bench for rib_xbar against a transaction-level model
module tb_rib_xbar;
   localparam int NM = 2;
   localparam int NS = 2;
   localparam int T = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rib_xbar_if #(.NM(NM), .NS(NS)) bus ();
   rib_xbar #(.NM(NM), .NS(NS), .SLV_REGION(8'h10), .TIMEOUT(T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_fail = 0;
   int last_m = NM - 1;
   int region [NS] = '{0, 1};
   logic [NM-1:0] mreq, mwe;
   logic [31:0]   maddr [NM];
   logic [31:0]   mwdata [NM];
   logic [NM-1:0] exp_gnt, exp_rv;
   logic [NS-1:0] exp_sreq;
   logic [31:0]   exp_addr, exp_wdata, exp_rdata;
   logic          exp_we, exp_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ref_v);
      n_chk++;
      if (obs !== ref_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, ref_v, $time);
      end
   endtask

   function automatic int pick();
      for (int k = 1; k <= NM; k++) begin
         int c;
         c = (last_m + k) % NM;
         if (mreq[c]) return c;
      end
      return -1;
   endfunction

   function automatic int dec(input logic [31:0] a);
      for (int i = 0; i < NS; i++)
         if (int'(a[31:28]) == region[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] rand_addr();
      int nib;
      nib = ($urandom_range(3) != 0) ? $urandom_range(1) : $urandom_range(15, 2);
      return {nib[3:0], 28'($urandom)};
   endfunction

   task automatic drive_m();
      bus.m_req = mreq;
      bus.m_we = mwe;
      for (int m = 0; m < NM; m++) begin
         bus.m_addr[m] = maddr[m];
         bus.m_wdata[m] = mwdata[m];
      end
   endtask

   task automatic new_req(input int m, input logic [31:0] a, input logic we);
      mreq[m] = 1'b1;
      maddr[m] = a;
      mwe[m] = we;
      mwdata[m] = $urandom;
   endtask

   task automatic retire(input int w);
      mreq[w] = 1'b0;
      maddr[w] = $urandom;
      mwdata[w] = $urandom;
      mwe[w] = 1'($urandom);
      drive_m();
   endtask

   task automatic set_rsp(input int w, input logic e, input logic [31:0] d);
      exp_rv = NM'(1) << w;
      exp_err = e;
      exp_rdata = d;
   endtask

   task automatic drive_s(input int s, input logic g, input logic v, input logic [31:0] rd);
      bus.s_gnt = NS'($urandom);
      bus.s_gnt[s] = g;
      bus.s_rvalid = NS'($urandom);
      bus.s_rvalid[s] = v;
      for (int k = 0; k < NS; k++) bus.s_rdata[k] = $urandom;
      bus.s_rdata[s] = rd;
   endtask

   task automatic cyc();
      drive_m();
      @(negedge clk);
      chk("m_gnt", 32'(bus.m_gnt), 32'(exp_gnt));
      chk("s_req", 32'(bus.s_req), 32'(exp_sreq));
      chk("m_rvalid", 32'(bus.m_rvalid), 32'(exp_rv));
      if (exp_rv != 0) begin
         chk("m_rdata", bus.m_rdata, exp_rdata);
         chk("m_err", 32'(bus.m_err), 32'(exp_err));
      end
      if (exp_sreq != 0) begin
         chk("s_addr", bus.s_addr, exp_addr);
         chk("s_we", 32'(bus.s_we), 32'(exp_we));
         chk("s_wdata", bus.s_wdata, exp_wdata);
      end
      @(posedge clk);
      #1;
      exp_gnt = '0;
      exp_sreq = '0;
      exp_rv = '0;
      bus.s_gnt = '0;
      bus.s_rvalid = '0;
   endtask

   task automatic chk_zero(input string tag);
      @(negedge clk);
      chk({tag, "_m_gnt"}, 32'(bus.m_gnt), 32'h0);
      chk({tag, "_m_rvalid"}, 32'(bus.m_rvalid), 32'h0);
      chk({tag, "_m_rdata"}, bus.m_rdata, 32'h0);
      chk({tag, "_m_err"}, 32'(bus.m_err), 32'h0);
      chk({tag, "_s_req"}, 32'(bus.s_req), 32'h0);
      chk({tag, "_s_we"}, 32'(bus.s_we), 32'h0);
      chk({tag, "_s_addr"}, bus.s_addr, 32'h0);
      chk({tag, "_s_wdata"}, bus.s_wdata, 32'h0);
      @(posedge clk);
      #1;
   endtask

   // gw/rw: cycles the selected slave waits before s_gnt / s_rvalid; the REQ+RSP budget is T cycles.
   task automatic run_txn(input int gw, input int rw, input logic [31:0] rd);
      int w, s;
      w = pick();
      s = dec(maddr[w]);
      exp_addr = {4'h0, maddr[w][27:0]};
      exp_we = mwe[w];
      exp_wdata = mwdata[w];
      last_m = w;
      cyc();
      if (s < 0) begin
         exp_gnt = NM'(1) << w;
         cyc();
         retire(w);
         set_rsp(w, 1'b1, 32'h0);
         return;
      end
      for (int i = 0; i < T; i++) begin
         drive_s(s, i == gw, 1'b0, rd);
         exp_sreq = NS'(1) << s;
         if (i == gw || i == T - 1) begin
            exp_gnt = NM'(1) << w;
            cyc();
            retire(w);
            if (i != gw) begin
               set_rsp(w, 1'b1, 32'h0);
               return;
            end
            break;
         end
         cyc();
      end
      for (int j = 0; j <= T; j++) begin
         drive_s(s, 1'b0, j == rw, rd);
         cyc();
         if (j == rw) begin
            set_rsp(w, 1'b0, rd);
            break;
         end
         if (gw + 1 + j >= T - 1) begin
            set_rsp(w, 1'b1, 32'h0);
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w, s, gw, rw;
      mreq = '0;
      mwe = '0;
      for (int m = 0; m < NM; m++) begin
         maddr[m] = '0;
         mwdata[m] = '0;
      end
      exp_gnt = '0;
      exp_sreq = '0;
      exp_rv = '0;
      exp_err = 1'b0;
      exp_rdata = '0;
      exp_we = 1'b0;
      exp_addr = '0;
      exp_wdata = '0;
      bus.s_gnt = '0;
      bus.s_rvalid = '0;
      bus.s_rdata = '0;
      drive_m();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;

      new_req(0, 32'h1000_0010, 1'b0);
      run_txn(0, 0, 32'hDEAD_BEEF);

      repeat (4) begin
         for (int m = 0; m < NM; m++)
            if (!mreq[m]) new_req(m, {3'b000, 1'($urandom), 28'($urandom)}, 1'($urandom));
         run_txn(0, 0, $urandom);
      end
      mreq = '0;
      cyc();

      new_req(1, 32'h5000_0000, 1'b1);
      run_txn(0, 0, 32'h0);
      cyc();

      new_req(0, 32'h0000_0100, 1'b0);
      run_txn(T, 0, 32'h1234_5678);
      cyc();
      bus.s_rvalid = '1;
      bus.s_rdata[0] = 32'hCAFE_0000;
      cyc();

      repeat (150) begin
         for (int m = 0; m < NM; m++)
            if (!mreq[m] && $urandom_range(1) != 0) new_req(m, rand_addr(), 1'($urandom));
         if (mreq == 0) new_req(int'($urandom_range(NM - 1)), rand_addr(), 1'($urandom));
         gw = ($urandom_range(4) == 0) ? T : int'($urandom_range(T - 1));
         rw = (gw >= T - 1) ? 0 : int'($urandom_range(3));
         run_txn(gw, rw, $urandom);
      end
      mreq = '0;
      cyc();

      new_req(0, 32'h1000_0004, 1'b1);
      w = pick();
      s = dec(maddr[w]);
      exp_addr = {4'h0, maddr[w][27:0]};
      exp_we = mwe[w];
      exp_wdata = mwdata[w];
      last_m = w;
      cyc();
      drive_s(s, 1'b1, 1'b0, 32'h0);
      exp_sreq = NS'(1) << s;
      exp_gnt = NM'(1) << w;
      cyc();
      retire(w);
      rst = 1'b1;
      drive_s(s, 1'b0, 1'b1, 32'h5555_AAAA);
      cyc();
      chk_zero("rst_rsp");
      rst = 1'b0;
      last_m = NM - 1;
      for (int m = 0; m < NM; m++) new_req(m, {4'h1, 28'($urandom)}, 1'b0);
      run_txn(0, 0, $urandom);
      mreq = '0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
